// File: rtl/sd_pkg.sv
// Shared definitions for the SD-card SPI command engine: FSM states, frame geometry
// and the CRC7 generator polynomial with its single-bit update step.
package sd_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StWaitResp,
        StRecv,
        StFinish
    } sd_state_e;

    // Command frame: start(0), transmit(1), index[5:0], arg[31:0], crc7[6:0], end(1)
    localparam int unsigned FrameLen = 48;

    // x^7 + x^3 + 1, with the x^7 term implied by the shift
    localparam logic [6:0] Crc7Poly = 7'h09;

    // One serial CRC7 step, MSB-first data
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? Crc7Poly : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator. Clear has priority over enable; the value is consumed
// directly by the command engine when the CRC field is reached.
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       enable_i,
    input  logic       bit_i,
    output logic [6:0] crc_o
);

    logic [6:0] crc_q;

    // Synchronous reset, then clear, then one shift per enabled cycle
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            crc_q <= 7'h00;
        end else if (clear_i) begin
            crc_q <= 7'h00;
        end else if (enable_i) begin
            crc_q <= crc7_step(crc_q, bit_i);
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sd_spi_cmd_engine.sv
// SD-card SPI (mode 0) command engine: shifts out one 48-bit command frame with its
// CRC7, polls for the R1 response start bit, captures the response byte, and reports
// completion or timeout. SCLK advances only on sclk_en pulses, one half-period each.
module sd_spi_cmd_engine
    import sd_pkg::*;
#(
    parameter int unsigned NCR_MAX = 8
) (
    input  logic        clk,
    input  logic        sys_rst_n,
    input  logic        sclk_en,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        sd_miso,
    output logic        sd_sclk,
    output logic        sd_mosi,
    output logic        sd_cs_n,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [7:0]  resp
);

    localparam int unsigned PollMax = NCR_MAX * 8;
    localparam int unsigned PollW   = (PollMax > 1) ? $clog2(PollMax) : 1;

    sd_state_e           state_q;
    logic                sclk_q;
    logic                mosi_q;
    logic                cs_n_q;
    logic                busy_q;
    logic                done_q;
    logic                timeout_q;
    logic [7:0]          resp_q;
    logic [FrameLen-1:0] sh_q;        // sh_q[FrameLen-1] is the bit currently on MOSI
    logic [5:0]          bit_idx_q;   // frame bit on MOSI in SEND, bits left in RECV
    logic [PollW-1:0]    poll_cnt_q;
    logic [6:0]          rx_q;

    logic       rise_tick;
    logic       fall_tick;
    logic       crc_clr;
    logic       crc_en;
    logic       crc_bit;
    logic [6:0] crc;

    // Decode SCLK edges and feed the CRC with each frame bit as it is placed on MOSI
    always_comb begin
        rise_tick = sclk_en && !sclk_q;
        fall_tick = sclk_en && sclk_q;
        // Start bit 47 is always 0, so a cleared CRC already accounts for it
        crc_clr   = (state_q == StIdle);
        crc_en    = (state_q == StSend) && fall_tick && (bit_idx_q > 6'd8);
        crc_bit   = sh_q[FrameLen-2];
    end

    sd_crc7 u_crc7 (
        .clk_i    (clk),
        .rst_ni   (sys_rst_n),
        .clear_i  (crc_clr),
        .enable_i (crc_en),
        .bit_i    (crc_bit),
        .crc_o    (crc)
    );

    // Command FSM with registered SPI and status outputs
    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            state_q    <= StIdle;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b1;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            resp_q     <= 8'hFF;
            sh_q       <= '0;
            bit_idx_q  <= '0;
            poll_cnt_q <= '0;
            rx_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        sh_q       <= {2'b01, cmd_index, cmd_arg, 7'h00, 1'b1};
                        mosi_q     <= 1'b0;
                        bit_idx_q  <= 6'(FrameLen - 1);
                        poll_cnt_q <= '0;
                        cs_n_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        timeout_q  <= 1'b0;
                        state_q    <= StSend;
                    end
                end

                StSend: begin
                    if (rise_tick) begin
                        sclk_q <= 1'b1;
                    end else if (fall_tick) begin
                        sclk_q <= 1'b0;
                        if (bit_idx_q == 6'd0) begin
                            mosi_q  <= 1'b1;
                            state_q <= StWaitResp;
                        end else if (bit_idx_q == 6'd8) begin
                            // CRC now covers bits 47..8: splice it and the end bit in
                            sh_q      <= {crc, 1'b1, {(FrameLen - 8){1'b0}}};
                            mosi_q    <= crc[6];
                            bit_idx_q <= bit_idx_q - 6'd1;
                        end else begin
                            sh_q      <= {sh_q[FrameLen-2:0], 1'b0};
                            mosi_q    <= sh_q[FrameLen-2];
                            bit_idx_q <= bit_idx_q - 6'd1;
                        end
                    end
                end

                StWaitResp: begin
                    if (rise_tick) begin
                        sclk_q <= 1'b1;
                        if (!sd_miso) begin
                            rx_q      <= {rx_q[5:0], 1'b0};
                            bit_idx_q <= 6'd6;
                            state_q   <= StRecv;
                        end else if (poll_cnt_q == PollW'(PollMax - 1)) begin
                            timeout_q <= 1'b1;
                            resp_q    <= 8'hFF;
                            state_q   <= StFinish;
                        end else begin
                            poll_cnt_q <= poll_cnt_q + 1'b1;
                        end
                    end else if (fall_tick) begin
                        sclk_q <= 1'b0;
                    end
                end

                StRecv: begin
                    if (rise_tick) begin
                        sclk_q <= 1'b1;
                        rx_q   <= {rx_q[5:0], sd_miso};
                        if (bit_idx_q == 6'd0) begin
                            resp_q  <= {rx_q, sd_miso};
                            state_q <= StFinish;
                        end else begin
                            bit_idx_q <= bit_idx_q - 6'd1;
                        end
                    end else if (fall_tick) begin
                        sclk_q <= 1'b0;
                    end
                end

                StFinish: begin
                    // Release the card only once SCLK is back at its idle level
                    if (fall_tick) begin
                        sclk_q  <= 1'b0;
                        cs_n_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign sd_sclk = sclk_q;
    assign sd_mosi = mosi_q;
    assign sd_cs_n = cs_n_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign timeout = timeout_q;
    assign resp    = resp_q;

endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// Directed bench for sd_spi_cmd_engine: a small card model captures the MOSI frame on
// rising SCLK and answers on MISO after a programmable number of poll bytes.
module tb_sd_spi_cmd_engine;

    logic        clk = 1'b0;
    logic        sys_rst_n;
    logic        sclk_en;
    logic        start;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        sd_miso;
    logic        sd_sclk;
    logic        sd_mosi;
    logic        sd_cs_n;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [7:0]  resp;

    int n_tests = 0;
    int n_fail  = 0;

    // Results of the last run_cmd
    logic [47:0] r_frame;
    int          r_rise;
    int          r_ndone;
    logic [7:0]  r_resp;
    logic        r_to;
    logic        r_busy_after;

    always #5 clk = ~clk;

    sd_spi_cmd_engine #(
        .NCR_MAX (8)
    ) dut (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .sclk_en   (sclk_en),
        .start     (start),
        .cmd_index (cmd_index),
        .cmd_arg   (cmd_arg),
        .sd_miso   (sd_miso),
        .sd_sclk   (sd_sclk),
        .sd_mosi   (sd_mosi),
        .sd_cs_n   (sd_cs_n),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .resp      (resp)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one command and run the card model until 30 cycles after done.
    // dly: poll bytes of 0xFF before rbyte; stall_at/rst_at/dup_at: rising-edge counts
    // at which to stall sclk_en, assert reset, or pulse a second start (-1 = never).
    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg,
                           input logic [7:0] rbyte, input int dly, input int stall_at,
                           input int rst_at, input int dup_at);
        logic prev_sclk;
        logic en_phase;
        logic s_sclk;
        logic s_mosi;
        int   post;
        int   stall_left;
        int   s_rise;
        int   r;
        bit   stall_done;
        bit   dup_done;
        r_frame      = '0;
        r_rise       = 0;
        r_ndone      = 0;
        r_resp       = '0;
        r_to         = 1'b0;
        r_busy_after = 1'b0;
        prev_sclk    = 1'b0;
        post         = -1;
        stall_left   = 0;
        stall_done   = 0;
        dup_done     = 0;
        s_sclk       = 1'b0;
        s_mosi       = 1'b0;
        s_rise       = 0;

        @(negedge clk);
        cmd_index = idx;
        cmd_arg   = arg;
        start     = 1'b1;
        sclk_en   = 1'b0;
        sd_miso   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("start_busy", busy, 1);
        check_eq("start_cs_n", sd_cs_n, 0);
        check_eq("start_mosi_bit47", sd_mosi, 0);
        check_eq("start_timeout_clr", timeout, 0);
        sclk_en  = 1'b1;
        en_phase = 1'b0;

        for (int cyc = 0; cyc < 5000 && post != 0; cyc++) begin
            @(negedge clk);
            if (sd_sclk && !prev_sclk) begin
                if (r_rise < 48) r_frame = {r_frame[46:0], sd_mosi};
                r_rise++;
            end
            prev_sclk = sd_sclk;

            if (post > 0) begin
                post--;
                if (busy) r_busy_after = 1'b1;
                if (done) r_ndone++;
            end else if (done) begin
                r_ndone++;
                r_resp = resp;
                r_to   = timeout;
                check_eq("done_busy", busy, 0);
                check_eq("done_cs_n", sd_cs_n, 1);
                check_eq("done_sclk", sd_sclk, 0);
                post = 30;
            end

            if (rst_at >= 0 && r_rise == rst_at) begin
                sys_rst_n = 1'b0;
                sclk_en   = 1'b0;
                @(negedge clk);
                check_eq("rst_cs_n", sd_cs_n, 1);
                check_eq("rst_sclk", sd_sclk, 0);
                check_eq("rst_busy", busy, 0);
                check_eq("rst_mosi", sd_mosi, 1);
                sys_rst_n = 1'b1;
                return;
            end

            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) begin
                    check_eq("stall_sclk", sd_sclk, s_sclk);
                    check_eq("stall_mosi", sd_mosi, s_mosi);
                    check_eq("stall_bitcnt", r_rise, s_rise);
                    check_eq("stall_busy", busy, 1);
                end
            end else if (stall_at >= 0 && !stall_done && r_rise == stall_at) begin
                stall_done = 1;
                stall_left = 100;
                s_sclk     = sd_sclk;
                s_mosi     = sd_mosi;
                s_rise     = r_rise;
            end

            start = 1'b0;
            if (dup_at >= 0 && !dup_done && r_rise == dup_at) begin
                dup_done = 1;
                start    = 1'b1;
            end

            r = r_rise - 48;
            if (r >= dly * 8 && r < dly * 8 + 8) sd_miso = rbyte[3'(7 - (r - dly * 8))];
            else sd_miso = 1'b1;

            if (stall_left > 0) begin
                sclk_en = 1'b0;
            end else begin
                sclk_en  = en_phase;
                en_phase = !en_phase;
            end
        end
        start   = 1'b0;
        sclk_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic sclk_hi;
        sys_rst_n = 1'b0;
        sclk_en   = 1'b0;
        start     = 1'b0;
        cmd_index = '0;
        cmd_arg   = '0;
        sd_miso   = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("reset_sclk", sd_sclk, 0);
        check_eq("reset_mosi", sd_mosi, 1);
        check_eq("reset_cs_n", sd_cs_n, 1);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_timeout", timeout, 0);
        check_eq("reset_resp", resp, 8'hFF);
        sys_rst_n = 1'b1;

        // sclk_en pulses while idle must not move SCLK
        sclk_hi = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sclk_en = ~sclk_en;
            @(negedge clk);
            if (sd_sclk) sclk_hi = 1'b1;
        end
        sclk_en = 1'b0;
        check_eq("idle_sclk_low", sclk_hi, 0);
        check_eq("idle_cs_n", sd_cs_n, 1);

        // CMD0, response 0x01 after two poll bytes
        run_cmd(6'd0, 32'h0, 8'h01, 2, -1, -1, -1);
        check_eq("cmd0_frame", r_frame, 48'h40_0000_0000_95);
        check_eq("cmd0_rises", r_rise, 72);
        check_eq("cmd0_resp", r_resp, 8'h01);
        check_eq("cmd0_timeout", r_to, 0);
        check_eq("cmd0_ndone", r_ndone, 1);
        check_eq("cmd0_resp_hold", resp, 8'h01);

        // CMD8, immediate response
        run_cmd(6'd8, 32'h0000_01AA, 8'h01, 0, -1, -1, -1);
        check_eq("cmd8_frame", r_frame, 48'h48_0000_01AA_87);
        check_eq("cmd8_rises", r_rise, 56);
        check_eq("cmd8_resp", r_resp, 8'h01);
        check_eq("cmd8_ndone", r_ndone, 1);

        // No card response: 64 poll ticks then timeout
        run_cmd(6'd0, 32'h0, 8'h00, 1000, -1, -1, -1);
        check_eq("to_frame", r_frame, 48'h40_0000_0000_95);
        check_eq("to_rises", r_rise, 112);
        check_eq("to_timeout", r_to, 1);
        check_eq("to_resp", r_resp, 8'hFF);
        check_eq("to_ndone", r_ndone, 1);
        check_eq("to_timeout_hold", timeout, 1);

        // Second start during SEND is ignored and not queued
        run_cmd(6'd0, 32'h0, 8'h01, 1, -1, -1, 10);
        check_eq("dup_frame", r_frame, 48'h40_0000_0000_95);
        check_eq("dup_rises", r_rise, 64);
        check_eq("dup_ndone", r_ndone, 1);
        check_eq("dup_no_requeue", r_busy_after, 0);
        check_eq("dup_resp", r_resp, 8'h01);

        // Reset mid-SEND, then a clean CMD0
        run_cmd(6'd0, 32'h0, 8'h01, 1, -1, 28, -1);
        run_cmd(6'd0, 32'h0, 8'h01, 2, -1, -1, -1);
        check_eq("post_rst_frame", r_frame, 48'h40_0000_0000_95);
        check_eq("post_rst_resp", r_resp, 8'h01);
        check_eq("post_rst_timeout", r_to, 0);
        check_eq("post_rst_ndone", r_ndone, 1);

        // 100-cycle sclk_en stall mid-SEND
        run_cmd(6'd8, 32'h0000_01AA, 8'h01, 1, 20, -1, -1);
        check_eq("stall_frame", r_frame, 48'h48_0000_01AA_87);
        check_eq("stall_rises", r_rise, 64);
        check_eq("stall_resp", r_resp, 8'h01);
        check_eq("stall_ndone", r_ndone, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_spi_cmd_engine.md
SD_SPI_CMD_ENGINE -- requirements
Module: sd_spi_cmd_engine

Interface
REQ-001 SHALL have parameter NCR_MAX, default 8, the maximum number of response-wait bytes polled before timeout.
REQ-002 SHALL have port clk, input, 1, the single system clock.
REQ-003 SHALL have port sys_rst_n, input, 1, synchronous active-low reset.
REQ-004 SHALL have port sclk_en, input, 1, one-cycle enable pulse from the 25 MHz divider; each pulse is one SCLK half-period.
REQ-005 SHALL have port start, input, 1, command request, sampled only when idle.
REQ-006 SHALL have port cmd_index, input, 6, SD command index.
REQ-007 SHALL have port cmd_arg, input, 32, command argument.
REQ-008 SHALL have port sd_miso, input, 1, card data out.
REQ-009 SHALL have port sd_sclk, output, 1, SPI clock (mode 0, idle low).
REQ-010 SHALL have port sd_mosi, output, 1, card data in.
REQ-011 SHALL have port sd_cs_n, output, 1, active-low chip select.
REQ-012 SHALL have port busy, output, 1, high from start acceptance until done.
REQ-013 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-014 SHALL have port timeout, output, 1, valid with done; high if no response arrived.
REQ-015 SHALL have port resp, output, 8, R1 response byte, valid with done.

Function
REQ-016 SHALL use states IDLE, SEND, WAIT_RESP, RECV, FINISH.
REQ-017 In IDLE with start=1, SHALL latch cmd_index and cmd_arg, assert busy and sd_cs_n=0, drive sd_mosi with frame bit 47, and enter SEND on the next cycle.
REQ-018 Frame SHALL be 48 bits, MSB first: 0, 1, cmd_index[5:0], cmd_arg[31:0], CRC7[6:0], 1.
REQ-019 CRC7 SHALL use polynomial x^7+x^3+1 with zero initial value, computed serially over frame bits 47..8 as they are shifted.
REQ-020 SHALL change sd_sclk only in cycles where sclk_en=1, toggling it once per pulse.
REQ-021 Rising SCLK ticks SHALL leave sd_mosi stable. Falling SCLK ticks SHALL advance sd_mosi to the next frame bit.
REQ-022 After the falling tick following bit 0, SHALL hold sd_mosi=1 and enter WAIT_RESP.
REQ-023 In WAIT_RESP, SHALL sample sd_miso on each rising tick. The first sampled 0 SHALL be resp[7], and the state SHALL move to RECV.
REQ-024 In RECV, SHALL shift 7 further rising-tick samples into resp[6:0], MSB first.
REQ-025 If NCR_MAX*8 rising ticks in WAIT_RESP all sample 1, SHALL set timeout=1, set resp=8'hFF, and enter FINISH.
REQ-026 FINISH SHALL wait for the next falling tick (sd_sclk returns low), then for one cycle set sd_cs_n=1 and busy=0, pulse done, and return to IDLE.
REQ-027 start SHALL be ignored while busy=1; it is not queued.
REQ-028 sclk_en asserted in IDLE SHALL have no effect: sd_sclk stays low.
REQ-029 resp and timeout SHALL hold their values until the next accepted start, which SHALL clear timeout.
REQ-030 If sclk_en stalls, all outputs SHALL hold and no state SHALL advance.

Reset
REQ-031 When sys_rst_n=0 at a clk edge, including mid-transfer, the block SHALL return to IDLE with sd_sclk=0, sd_mosi=1, sd_cs_n=1, busy=0, done=0, timeout=0, resp=8'hFF.

Structure
REQ-032 The state enum, frame length (48), and CRC7 polynomial constant SHALL live in a shared package, sd_pkg.
REQ-033 Serial CRC7 SHALL be a sub-module, sd_crc7, with clear, enable and bit-in inputs and a 7-bit output.

Verification
REQ-034 CMD0, arg 0 -> MOSI bytes 40 00 00 00 00 95. Card returns 0x01 after 2 poll bytes -> done=1, resp=8'h01, timeout=0.
REQ-035 CMD8, arg 32'h000001AA -> MOSI bytes 48 00 00 01 AA 87. Card response 0x01 is received correctly.
REQ-036 sd_miso held at 1 with NCR_MAX=8 -> after 64 rising poll ticks, done with timeout=1 and resp=8'hFF.
REQ-037 Second start pulsed during SEND -> ignored; exactly 48 MOSI bits are sent and one done pulse occurs.
REQ-038 sys_rst_n asserted at bit 20 of SEND -> next cycle has sd_cs_n=1, sd_sclk=0, busy=0. A following CMD0 completes correctly.
REQ-039 sclk_en held low for 100 cycles mid-SEND -> sd_sclk, sd_mosi and the bit count are frozen, and the transfer resumes without error.
